// File: rtl/lab2_proc_mem_req_tracker_if.sv
// Processor/memory request and response handshake bundle for lab2_proc_mem_req_tracker.
// master: the tracker's view; slave: the surrounding processor/memory view.
interface lab2_proc_mem_req_tracker_if #(
    parameter int unsigned p_req_nbits  = 77,
    parameter int unsigned p_resp_nbits = 47
);
    logic [p_req_nbits-1:0]  ireq_msg;
    logic                    ireq_val;
    logic                    ireq_rdy;
    logic [p_req_nbits-1:0]  oreq_msg;
    logic                    oreq_val;
    logic                    oreq_rdy;
    logic [p_resp_nbits-1:0] iresp_msg;
    logic                    iresp_val;
    logic                    iresp_rdy;
    logic [p_resp_nbits-1:0] oresp_msg;
    logic                    oresp_val;
    logic                    oresp_rdy;

    modport master (
        input  ireq_msg, ireq_val,
        output ireq_rdy,
        output oreq_msg, oreq_val,
        input  oreq_rdy,
        input  iresp_msg, iresp_val,
        output iresp_rdy,
        output oresp_msg, oresp_val,
        input  oresp_rdy
    );

    modport slave (
        output ireq_msg, ireq_val,
        input  ireq_rdy,
        input  oreq_msg, oreq_val,
        output oreq_rdy,
        output iresp_msg, iresp_val,
        input  iresp_rdy,
        input  oresp_msg, oresp_val,
        output oresp_rdy
    );
endinterface

// File: rtl/lab2_proc_mem_req_tracker.sv
// Forwards memory requests, counts in-flight ones, and drops responses owed to squashed requests.
// Optional simulation checks: define LAB2_PROC_MEM_REQ_TRACKER_ASSERT_EN.
module lab2_proc_mem_req_tracker #(
    parameter int unsigned p_req_nbits    = 77,
    parameter int unsigned p_resp_nbits   = 47,
    parameter int unsigned p_max_inflight = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 squash,
    lab2_proc_mem_req_tracker_if.master          io,
    output logic [$clog2(p_max_inflight+1)-1:0]  inflight
);
    localparam int unsigned CNT_W = $clog2(p_max_inflight + 1);

    typedef enum logic {PASS, DROP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [p_req_nbits-1:0]  req_msg;
    logic [p_resp_nbits-1:0] resp_msg;
    logic full;
    logic ireq_rdy, oreq_val, iresp_rdy, oresp_val;
    logic req_go, resp_go, resp_dec;

    assign req_msg      = io.ireq_msg;
    assign resp_msg     = io.iresp_msg;
    assign io.oreq_msg  = req_msg;
    assign io.oresp_msg = resp_msg;
    assign io.ireq_rdy  = ireq_rdy;
    assign io.oreq_val  = oreq_val;
    assign io.iresp_rdy = iresp_rdy;
    assign io.oresp_val = oresp_val;
    assign inflight     = inflight_q;

    assign full = (inflight_q == CNT_W'(p_max_inflight));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PASS;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Handshake outputs are held low for as long as reset is asserted.
    always_comb begin
        ireq_rdy  = 1'b0;
        oreq_val  = 1'b0;
        iresp_rdy = 1'b0;
        oresp_val = 1'b0;
        if (reset) begin
            ireq_rdy = io.oreq_rdy & ~full & ~squash;
            oreq_val = io.ireq_val & ~full & ~squash;
            case (state_q)
                DROP: begin
                    iresp_rdy = 1'b1;
                    oresp_val = 1'b0;
                end
                default: begin
                    iresp_rdy = io.oresp_rdy;
                    oresp_val = io.iresp_val & ~squash;
                end
            endcase
        end
    end

    always_comb begin
        req_go   = oreq_val & io.oreq_rdy;
        resp_go  = io.iresp_val & iresp_rdy;
        resp_dec = resp_go & (inflight_q != '0);

        inflight_d = inflight_q;
        case ({req_go, resp_dec})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        // Squash re-arms the drop count from the post-cycle count and wins over a decrement.
        if (squash) begin
            drop_cnt_d = inflight_d;
            state_d    = (inflight_d != '0) ? DROP : PASS;
        end else if ((state_q == DROP) && resp_go) begin
            if (drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (drop_cnt_q == CNT_W'(1)) begin
                state_d = PASS;
            end
        end
    end

`ifdef LAB2_PROC_MEM_REQ_TRACKER_ASSERT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            if (resp_go && (inflight_q == '0))
                $error("response accepted with no request in flight");
            if (32'(inflight_q) > p_max_inflight)
                $error("inflight count %0d exceeds limit", inflight_q);
            if ((state_q == DROP) && oresp_val)
                $error("response forwarded while dropping");
            if ($isunknown({ireq_rdy, oreq_val, iresp_rdy, oresp_val}))
                $error("handshake output is X after reset release");
        end
    end
`else
    // No runtime checks in this build.
`endif

endmodule

// File: tb/tb_lab2_proc_mem_req_tracker.sv
// Self-checking bench for lab2_proc_mem_req_tracker: directed scenarios plus a random run
// checked against a queue of outstanding requests, each tagged keep/discard.
module tb_lab2_proc_mem_req_tracker;
    localparam int REQ_W  = 77;
    localparam int RESP_W = 47;
    localparam int MAX    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       squash;
    logic [2:0] inflight;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // One entry per outstanding request, in issue order; 1 = its response must be dropped.
    bit q[$];
    logic e_ireq_rdy, e_oreq_val, e_iresp_rdy, e_oresp_val;

    always #5 clk = ~clk;

    lab2_proc_mem_req_tracker_if #(.p_req_nbits(REQ_W), .p_resp_nbits(RESP_W)) io ();

    lab2_proc_mem_req_tracker #(
        .p_req_nbits   (REQ_W),
        .p_resp_nbits  (RESP_W),
        .p_max_inflight(MAX)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .squash  (squash),
        .io      (io),
        .inflight(inflight)
    );

    task automatic idle_inputs();
        squash       = 1'b0;
        io.ireq_val  = 1'b0;
        io.oreq_rdy  = 1'b0;
        io.iresp_val = 1'b0;
        io.oresp_rdy = 1'b0;
        io.ireq_msg  = '0;
        io.iresp_msg = '0;
    endtask

    // Apply one cycle of inputs (just after negedge) and derive the expected handshake outputs.
    task automatic drive(input logic iv, input logic mem_rdy, input logic sq,
                         input logic rv, input logic proc_rdy);
        logic [95:0] t;
        bit full, dropping;
        squash       = sq;
        io.ireq_val  = iv;
        io.oreq_rdy  = mem_rdy;
        io.iresp_val = rv;
        io.oresp_rdy = proc_rdy;
        t = {$urandom(), $urandom(), $urandom()};
        io.ireq_msg = t[REQ_W-1:0];
        t = {$urandom(), $urandom(), $urandom()};
        io.iresp_msg = t[RESP_W-1:0];
        full        = (q.size() == MAX);
        dropping    = (q.size() != 0) && q[0];
        e_ireq_rdy  = mem_rdy && !full && !sq;
        e_oreq_val  = iv && !full && !sq;
        e_iresp_rdy = dropping ? 1'b1 : proc_rdy;
        e_oresp_val = dropping ? 1'b0 : (rv && !sq);
        #1;
    endtask

    // Clock edge: retire the oldest entry on a response, append on a request, tag all on squash.
    task automatic advance();
        bit req_go, resp_go, sq;
        req_go  = e_oreq_val && io.oreq_rdy;
        resp_go = io.iresp_val && e_iresp_rdy;
        sq      = squash;
        @(posedge clk);
        if (resp_go && q.size() != 0) void'(q.pop_front());
        if (req_go) q.push_back(1'b0);
        if (sq) foreach (q[i]) q[i] = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic issue(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 1, 0, 0, 0);
            advance();
        end
    endtask

    task automatic test_reset();
        do_reset();
        issue(3);
        checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL reset_pre_inflight got=%0d exp=3", inflight); end
        drive(1, 1, 0, 1, 1);
        reset = 1'b0;
        #1;
        checks++; if ({io.ireq_rdy, io.oreq_val, io.iresp_rdy, io.oresp_val} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs got=%b exp=0000", {io.ireq_rdy, io.oreq_val, io.iresp_rdy, io.oresp_val});
        end
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1, 0, 0, 0);
        checks++; if (io.oreq_val !== 1'b1 || io.ireq_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_first_req oreq_val=%b ireq_rdy=%b exp=1 1", io.oreq_val, io.ireq_rdy);
        end
        checks++; if (io.oreq_msg !== io.ireq_msg) begin errors++; $display("FAIL reset_req_msg got=%h exp=%h", io.oreq_msg, io.ireq_msg); end
        advance();
        drive(0, 0, 0, 1, 0);
        checks++; if (io.iresp_rdy !== 1'b0 || io.oresp_val !== 1'b1) begin
            errors++; $display("FAIL reset_state_pass iresp_rdy=%b oresp_val=%b exp=0 1", io.iresp_rdy, io.oresp_val);
        end
    endtask

    task automatic test_full();
        do_reset();
        issue(4);
        drive(1, 1, 0, 0, 0);
        checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL full_inflight got=%0d exp=4", inflight); end
        checks++; if (io.ireq_rdy !== 1'b0 || io.oreq_val !== 1'b0) begin
            errors++; $display("FAIL full_block ireq_rdy=%b oreq_val=%b exp=0 0", io.ireq_rdy, io.oreq_val);
        end
        advance();
        drive(0, 1, 0, 1, 1);
        checks++; if (io.oresp_val !== 1'b1 || io.oresp_msg !== io.iresp_msg) begin
            errors++; $display("FAIL full_resp oresp_val=%b msg=%h exp=1 %h", io.oresp_val, io.oresp_msg, io.iresp_msg);
        end
        advance();
        drive(1, 1, 0, 0, 0);
        checks++; if (inflight !== 3'd3 || io.ireq_rdy !== 1'b1) begin
            errors++; $display("FAIL full_after_resp inflight=%0d ireq_rdy=%b exp=3 1", inflight, io.ireq_rdy);
        end
        advance();
    endtask

    task automatic test_squash_drop();
        do_reset();
        issue(3);
        drive(0, 0, 1, 0, 0);
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 0);
            checks++; if (io.iresp_rdy !== 1'b1 || io.oresp_val !== 1'b0) begin
                errors++; $display("FAIL squash_drop_%0d iresp_rdy=%b oresp_val=%b exp=1 0", k, io.iresp_rdy, io.oresp_val);
            end
            advance();
        end
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL squash_drop_inflight got=%0d exp=0", inflight); end
        issue(1);
        drive(0, 0, 0, 1, 0);
        checks++; if (io.iresp_rdy !== 1'b0 || io.oresp_val !== 1'b1) begin
            errors++; $display("FAIL squash_drop_back_to_pass iresp_rdy=%b oresp_val=%b exp=0 1", io.iresp_rdy, io.oresp_val);
        end
    endtask

    task automatic test_squash_with_resp();
        do_reset();
        issue(2);
        drive(0, 0, 1, 1, 1);
        checks++; if (io.oresp_val !== 1'b0 || io.iresp_rdy !== 1'b1) begin
            errors++; $display("FAIL sqresp_same_cycle oresp_val=%b iresp_rdy=%b exp=0 1", io.oresp_val, io.iresp_rdy);
        end
        advance();
        checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL sqresp_inflight got=%0d exp=1", inflight); end
        drive(0, 0, 0, 1, 0);
        checks++; if (io.iresp_rdy !== 1'b1 || io.oresp_val !== 1'b0) begin
            errors++; $display("FAIL sqresp_second_drop iresp_rdy=%b oresp_val=%b exp=1 0", io.iresp_rdy, io.oresp_val);
        end
        advance();
        issue(1);
        drive(0, 0, 0, 1, 1);
        checks++; if (io.oresp_val !== 1'b1) begin errors++; $display("FAIL sqresp_pass oresp_val=%b exp=1", io.oresp_val); end
        advance();
    endtask

    task automatic test_req_during_drop();
        do_reset();
        issue(2);
        drive(0, 0, 1, 0, 0);
        advance();
        drive(1, 1, 0, 0, 0);
        checks++; if (io.oreq_val !== 1'b1) begin errors++; $display("FAIL drop_new_req oreq_val=%b exp=1", io.oreq_val); end
        advance();
        checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL drop_new_inflight got=%0d exp=3", inflight); end
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 1, 1);
            checks++; if (io.oresp_val !== 1'b0 || io.iresp_rdy !== 1'b1) begin
                errors++; $display("FAIL drop_new_drop_%0d oresp_val=%b iresp_rdy=%b exp=0 1", k, io.oresp_val, io.iresp_rdy);
            end
            advance();
        end
        drive(0, 0, 0, 1, 1);
        io.iresp_msg = 47'h1234;
        #1;
        checks++; if (io.oresp_val !== 1'b1 || io.oresp_msg !== 47'h1234) begin
            errors++; $display("FAIL drop_new_deliver oresp_val=%b msg=%h exp=1 1234", io.oresp_val, io.oresp_msg);
        end
        advance();
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL drop_new_final got=%0d exp=0", inflight); end
    endtask

    task automatic test_squash_blocks_req();
        do_reset();
        issue(2);
        drive(1, 1, 1, 0, 0);
        checks++; if (io.oreq_val !== 1'b0 || io.ireq_rdy !== 1'b0) begin
            errors++; $display("FAIL sqblock oreq_val=%b ireq_rdy=%b exp=0 0", io.oreq_val, io.ireq_rdy);
        end
        advance();
        checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL sqblock_inflight got=%0d exp=2", inflight); end
    endtask

    task automatic test_random();
        logic rv;
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            rv = (q.size() != 0) && ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 11) == 0, rv, $urandom_range(0, 1) == 1);
            checks++; if (io.ireq_rdy !== e_ireq_rdy) begin errors++; $display("FAIL rnd_ireq_rdy cyc=%0d got=%b exp=%b", cyc, io.ireq_rdy, e_ireq_rdy); end
            checks++; if (io.oreq_val !== e_oreq_val) begin errors++; $display("FAIL rnd_oreq_val cyc=%0d got=%b exp=%b", cyc, io.oreq_val, e_oreq_val); end
            checks++; if (io.iresp_rdy !== e_iresp_rdy) begin errors++; $display("FAIL rnd_iresp_rdy cyc=%0d got=%b exp=%b", cyc, io.iresp_rdy, e_iresp_rdy); end
            checks++; if (io.oresp_val !== e_oresp_val) begin errors++; $display("FAIL rnd_oresp_val cyc=%0d got=%b exp=%b", cyc, io.oresp_val, e_oresp_val); end
            checks++; if (inflight !== 3'(q.size())) begin errors++; $display("FAIL rnd_inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, q.size()); end
            if (e_oresp_val) begin
                checks++; if (io.oresp_msg !== io.iresp_msg) begin errors++; $display("FAIL rnd_oresp_msg cyc=%0d got=%h exp=%h", cyc, io.oresp_msg, io.iresp_msg); end
            end
            advance();
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_full();
        test_squash_drop();
        test_squash_with_resp();
        test_req_during_drop();
        test_squash_blocks_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
